store_buffer: RTL and testbench

Posted-write buffer between the store alignment stage and the data-memory/MMIO write port. It accepts byte-masked, word-aligned store requests, queues up to DEPTH of them, and drains them in order through a valid/ready port. Loads that would read a word with a pending store are stalled. An optional feature merges consecutive stores to the same word.

---
 rtl/store_buffer_pkg.sv | 25 ++
 rtl/sb_addr_match.sv | 25 ++
 rtl/store_buffer.sv | 151 +++++++++++++++
 tb/tb_store_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared memory-interface constants for the store buffer.
// Holds the byte-lane count, the word-offset width, the mask and data widths,
// and a lane-merge helper.
package store_buffer_pkg;

  localparam int LANES  = 4;          // byte lanes per data word
  localparam int WOFF_W = 2;          // byte-offset bits inside a word
  localparam int MASK_W = LANES;      // one byte-enable per lane
  localparam int DATA_W = 8 * LANES;  // data word width

  // Overwrite the lanes of old_data that are selected by mask with new_data.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_data,
    input logic [DATA_W-1:0] new_data,
    input logic [MASK_W-1:0] mask
  );
    logic [DATA_W-1:0] r;
    r = old_data;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) r[8*i +: 8] = new_data[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sb_addr_match.sv
// DEPTH-wide word-address comparator.
// Compares one word address against every entry address and returns a hit
// vector. Each bit is gated by the matching entry's valid bit.
//   addr        : word address to look up
//   entry_addr  : packed array of entry word addresses
//   entry_valid : per-entry qualifier
//   hit         : per-entry match vector
module sb_addr_match #(
  parameter int DEPTH = 4,
  parameter int WAW   = 30
) (
  input  logic [WAW-1:0]            addr,
  input  logic [DEPTH-1:0][WAW-1:0] entry_addr,
  input  logic [DEPTH-1:0]          entry_valid,
  output logic [DEPTH-1:0]          hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = entry_valid[i] && (entry_addr[i] == addr);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer.
// This is an in-order circular FIFO of byte-masked word stores. Entries leave
// it through a valid/ready memory port. A load whose word matches any pending
// entry is stalled.
// Optional feature macro: STORE_BUF_MERGE_EN. When it is defined, a store to
// the same word as the most recent entry is merged into that entry.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in_valid/in_ready                 store request handshake
//   in_addr/in_data/in_mask           store byte address, lane data, byte enables
//   mem_req_valid/mem_req_ready       head-entry drain handshake
//   mem_addr/mem_wdata/mem_wmask      head entry contents
//   ld_check_valid/ld_check_addr      load hazard probe
//   ld_stall                          load word matches a pending entry
//   count, empty                      occupancy
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AWIDTH-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [MASK_W-1:0]        in_mask,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [AWIDTH-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [MASK_W-1:0]        mem_wmask,
  input  logic                     ld_check_valid,
  input  logic [AWIDTH-1:0]        ld_check_addr,
  output logic                     ld_stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW  = $clog2(DEPTH);
  localparam int WAW = AWIDTH - WOFF_W;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][WAW-1:0]    ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [DEPTH-1:0][MASK_W-1:0] ent_mask;
  logic [DEPTH-1:0]             ent_valid;
  logic [PW-1:0]                head, tail;

  logic           full, pop, has_bytes, accept, alloc, merge_hit;
  logic [WAW-1:0] in_word;
  logic [DEPTH-1:0] ld_hit;

  // The byte offsets are ignored by design. Only the word addresses matter.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{in_addr[WOFF_W-1:0], ld_check_addr[WOFF_W-1:0]};

  assign in_word   = in_addr[AWIDTH-1:WOFF_W];
  assign has_bytes = |in_mask;
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign pop       = mem_req_valid && mem_req_ready;

  // An entry that is being popped this cycle is still valid here, so it still
  // stalls the load. A store pushed in this same cycle is not yet valid.
  sb_addr_match #(.DEPTH(DEPTH), .WAW(WAW)) u_ld_match (
    .addr        (ld_check_addr[AWIDTH-1:WOFF_W]),
    .entry_addr  (ent_addr),
    .entry_valid (ent_valid),
    .hit         (ld_hit)
  );
  assign ld_stall = ld_check_valid && |ld_hit;

`ifdef STORE_BUF_MERGE_EN
  logic [PW-1:0]    last;
  logic [DEPTH-1:0] tail_hit;
  logic             merge_cand;

  assign last = tail - 1'b1;

  sb_addr_match #(.DEPTH(DEPTH), .WAW(WAW)) u_tail_match (
    .addr        (in_word),
    .entry_addr  (ent_addr),
    .entry_valid (ent_valid & (DEPTH'(1) << last)),
    .hit         (tail_hit)
  );

  assign merge_cand = has_bytes && |tail_hit;
  // The newest entry can only be the one leaving when it is the sole entry.
  // The buffer is then not full, so in_ready uses merge_cand. This keeps
  // mem_req_ready out of the in_ready path.
  assign merge_hit  = merge_cand && !(pop && count == (PW+1)'(1));
  assign in_ready   = !full || merge_cand;
`else
  assign merge_hit  = 1'b0;
  assign in_ready   = !full;
`endif

  assign accept = in_valid && in_ready;
  assign alloc  = accept && has_bytes && !merge_hit;

  // Outputs are forced to zero when the buffer is empty. The payload storage
  // is never reset, so it must not show through.
  assign mem_req_valid = !empty;
  assign mem_addr      = mem_req_valid ? {ent_addr[head], {WOFF_W{1'b0}}} : '0;
  assign mem_wdata     = mem_req_valid ? ent_data[head] : '0;
  assign mem_wmask     = mem_req_valid ? ent_mask[head] : '0;

  // NOTE: Sequential state uses non-blocking assignments. Every flop then
  // samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      if (alloc) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      unique case ({alloc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: The payload array has no reset. Its validity is tracked by
  // ent_valid and count. Leaving it unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_addr[tail] <= in_word;
      ent_data[tail] <= in_data;
      ent_mask[tail] <= in_mask;
    end
`ifdef STORE_BUF_MERGE_EN
    else if (accept && merge_hit) begin
      ent_data[last] <= merge_lanes(ent_data[last], in_data, in_mask);
      ent_mask[last] <= ent_mask[last] | in_mask;
    end
`endif
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard testbench for store_buffer (DEPTH=4, AWIDTH=32).
// The stimulus threads push hand-computed expected writes into a queue.
// An independent monitor pops the queue whenever a memory write handshake
// occurs and compares the write against the expected entry.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_data;
  logic [3:0]  in_mask;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        ld_check_valid, ld_stall;
  logic [31:0] ld_check_addr;
  logic [2:0]  count;
  logic        empty;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  store_buffer #(.DEPTH(4), .AWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_mask(in_mask),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .ld_check_valid(ld_check_valid), .ld_check_addr(ld_check_addr),
    .ld_stall(ld_stall), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a write handshake that is visible at the falling edge completes
  // at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wr_addr", 64'(mem_addr),  64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
        check("wr_mask", 64'(mem_wmask), 64'(e.mask));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    exp_t e;
    e.addr = a; e.data = d; e.mask = m;
    sb_q.push_back(e);
  endtask

  // Present one request for one cycle. Call it at posedge+1. acc reports
  // whether the handshake completed.
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      output logic acc);
    in_valid = 1'b1; in_addr = a; in_data = d; in_mask = m;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_mask = 4'b0000;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    mem_req_ready = 1'b1;
    while ((sb_q.size() != 0 || empty !== 1'b1) && k < 50) begin
      tick(1);
      k++;
    end
    check(name, 64'(k < 50), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; in_mask = '0;
    mem_req_ready = 1'b0; ld_check_valid = 1'b1; ld_check_addr = 32'h0;
    #23;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_valid",    64'(mem_req_valid), 64'(0));
    check("rst_addr",     64'(mem_addr), 64'(0));
    check("rst_wdata",    64'(mem_wdata), 64'(0));
    check("rst_wmask",    64'(mem_wmask), 64'(0));
    check("rst_ld_stall", 64'(ld_stall), 64'(0));
    check("rst_count",    64'(count), 64'(0));
    check("rst_empty",    64'(empty), 64'(1));
    ld_check_valid = 1'b0;
    rst_n = 1'b1;
    tick(1);

    // Single push with the memory ready: the write is visible one cycle later.
    mem_req_ready = 1'b1;
    expect_wr(32'h100, 32'hDEADBEEF, 4'b1111);
    push(32'h100, 32'hDEADBEEF, 4'b1111, acc);
    check("p1_acc",   64'(acc), 64'(1));
    check("p1_valid", 64'(mem_req_valid), 64'(1));
    check("p1_addr",  64'(mem_addr), 64'(32'h100));
    check("p1_data",  64'(mem_wdata), 64'(32'hDEADBEEF));
    tick(1);
    check("p1_popped", 64'(empty), 64'(1));

    // Fill to full with ready low. A fifth push must be refused.
    mem_req_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_wr(32'(i * 16), 32'(i * 32'h01010101), 4'b1111);
      push(32'(i * 16 + i - 1), 32'(i * 32'h01010101), 4'b1111, acc);
      check("fill_acc", 64'(acc), 64'(1));
    end
    check("full_count",    64'(count), 64'(4));
    check("full_in_ready", 64'(in_ready), 64'(0));
    push(32'h50, 32'h55555555, 4'b1111, acc);
    check("fifth_refused", 64'(acc), 64'(0));
    check("fifth_count",   64'(count), 64'(4));
    mem_req_ready = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      tick(1);
      check("drain_count", 64'(count), 64'(i));
    end
    mem_req_ready = 1'b0;

    // Back-to-back pushes with simultaneous pops hold the count at one.
    mem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_wr(32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 4'b0101);
      push(32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 4'b0101, acc);
      check("b2b_count", 64'(count), 64'(1));
    end
    tick(1);
    check("b2b_empty", 64'(empty), 64'(1));

    // Load hazard checks.
    mem_req_ready = 1'b0;
    expect_wr(32'h200, 32'h12345678, 4'b1111);
    push(32'h200, 32'h12345678, 4'b1111, acc);
    ld_check_valid = 1'b1; ld_check_addr = 32'h203; #1;
    check("ld_same_word", 64'(ld_stall), 64'(1));
    ld_check_addr = 32'h204; #1;
    check("ld_next_word", 64'(ld_stall), 64'(0));
    ld_check_addr = 32'h1FC; #1;
    check("ld_prev_word", 64'(ld_stall), 64'(0));
    ld_check_valid = 1'b0; ld_check_addr = 32'h200; #1;
    check("ld_not_valid", 64'(ld_stall), 64'(0));
    // A store being pushed in this same cycle does not stall the load.
    ld_check_valid = 1'b1; ld_check_addr = 32'h208;
    in_valid = 1'b1; in_addr = 32'h208; in_data = 32'h9; in_mask = 4'b0001; #1;
    check("ld_pushing", 64'(ld_stall), 64'(0));
    expect_wr(32'h208, 32'h9, 4'b0001);
    @(posedge clk); #1;
    in_valid = 1'b0; in_mask = 4'b0000;
    check("ld_pushed", 64'(ld_stall), 64'(1));
    // The entry being popped this cycle still stalls the load.
    ld_check_addr = 32'h200; mem_req_ready = 1'b1; #1;
    check("ld_popping", 64'(ld_stall), 64'(1));
    ld_check_valid = 1'b0;
    drain("ld_drain");
    mem_req_ready = 1'b0;

    // Two byte stores to the same word.
    push(32'h300, 32'h00000011, 4'b0001, acc);
    push(32'h301, 32'h00002200, 4'b0010, acc);
`ifdef STORE_BUF_MERGE_EN
    check("merge_count", 64'(count), 64'(1));
    expect_wr(32'h300, 32'h00002211, 4'b0011);
`else
    check("merge_count", 64'(count), 64'(2));
    expect_wr(32'h300, 32'h00000011, 4'b0001);
    expect_wr(32'h300, 32'h00002200, 4'b0010);
`endif
    drain("merge_drain");
    mem_req_ready = 1'b0;

    // A zero-mask request is accepted and then discarded.
    push(32'h600, 32'hFFFFFFFF, 4'b0000, acc);
    check("zmask_acc",   64'(acc), 64'(1));
    check("zmask_count", 64'(count), 64'(0));
    mem_req_ready = 1'b1;
    tick(3);
    check("zmask_empty", 64'(empty), 64'(1));
    mem_req_ready = 1'b0;

    // Reset in the middle of a drain: pending stores are lost.
    for (int i = 0; i < 3; i++) begin
      push(32'h700 + 32'(4 * i), 32'hC0 + 32'(i), 4'b1111, acc);
    end
    check("pre_rst_count", 64'(count), 64'(3));
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rst_count",    64'(count), 64'(0));
    check("mid_rst_valid",    64'(mem_req_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    #2;
    rst_n = 1'b1;
    tick(1);
    mem_req_ready = 1'b1;
    tick(5);
    check("post_rst_empty", 64'(empty), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
